// File: rtl/fifo_replay_ctrl_pkg.sv
// Shared definitions for the fifo replay controller.
// Holds the FSM state encoding, default sizing and the largest batch the fifo can hold.
package fifo_replay_ctrl_pkg;

  localparam int unsigned FRC_NDEPTH  = 4;
  localparam int unsigned FRC_NPW     = 8;
  // The fifo cannot tell full from empty, so one slot is always unused.
  localparam int unsigned FRC_MAX_LEN = (1 << FRC_NDEPTH) - 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_REWIND = 3'd3,
    ST_REPLAY = 3'd4,
    ST_NEXT   = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

endpackage

// File: rtl/fifo_replay_ctrl_if.sv
// Control strobes between the replay controller and its fifo.
//   ofifo_write/read/rrst/wrst : controller -> fifo strobes
//   ififo_end                  : fifo -> controller, read pointer caught up with write pointer
interface fifo_replay_ctrl_if;

  logic ofifo_write;
  logic ofifo_read;
  logic ofifo_rrst;
  logic ofifo_wrst;
  logic ififo_end;

  modport master (
    output ofifo_write, ofifo_read, ofifo_rrst, ofifo_wrst,
    input  ififo_end
  );

  modport slave (
    input  ofifo_write, ofifo_read, ofifo_rrst, ofifo_wrst,
    output ififo_end
  );

endinterface

// File: rtl/fifo_replay_ctrl.sv
// Sequences one fifo as a replay buffer: loads ilen words, then replays them npass times.
// Ports:
//   iclk, iresetn          clock, synchronous active-high reset
//   istart, ilen, inpass   batch start (IDLE only), length and replay count
//   iin_valid / oin_ready  upstream handshake; accepted words are written into the fifo
//   fifo (master)          fifo write/read/rrst/wrst strobes and end flag
//   iout_ready             consumer can take a word next cycle
//   oout_valid, oout_last  fifo odata qualifier and last-word-of-pass marker
//   opass                  pass currently replayed
//   obusy, odone, oerr     not idle, batch-complete pulse, sticky over-read flag
module fifo_replay_ctrl
  import fifo_replay_ctrl_pkg::*;
#(
  parameter int unsigned NDEPTH = FRC_NDEPTH,
  parameter int unsigned NPW    = FRC_NPW
) (
  input  logic              iclk,
  input  logic              iresetn,
  input  logic              istart,
  input  logic [NDEPTH-1:0] ilen,
  input  logic [NPW-1:0]    inpass,
  input  logic              iin_valid,
  output logic              oin_ready,
  fifo_replay_ctrl_if.master fifo,
  input  logic              iout_ready,
  output logic              oout_valid,
  output logic              oout_last,
  output logic [NPW-1:0]    opass,
  output logic              obusy,
  output logic              odone,
  output logic              oerr
);

  state_t            state, state_nxt;
  logic [NDEPTH-1:0] len, wr_cnt, rd_cnt;
  logic [NPW-1:0]    npass;
  logic              start_c, write_c, read_c, rrst_c, wrst_c, pass_inc_c;

  // State register.
  always_ff @(posedge iclk) begin
    if (iresetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next state and strobes.
  always_comb begin
    state_nxt  = state;
    start_c    = 1'b0;
    oin_ready  = 1'b0;
    write_c    = 1'b0;
    read_c     = 1'b0;
    rrst_c     = 1'b0;
    wrst_c     = 1'b0;
    pass_inc_c = 1'b0;
    odone      = 1'b0;
    obusy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (istart) begin
          start_c   = 1'b1;
          state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        wrst_c    = 1'b1;
        rrst_c    = 1'b1;
        state_nxt = (len == '0) ? ST_DONE : ST_LOAD;
      end
      ST_LOAD: begin
        oin_ready = (wr_cnt < len);
        write_c   = iin_valid & oin_ready;
        if (wr_cnt == len) state_nxt = ST_REWIND;
      end
      ST_REWIND: begin
        rrst_c    = 1'b1;
        state_nxt = ST_REPLAY;
      end
      ST_REPLAY: begin
        read_c = iout_ready & (rd_cnt < len);
        if (rd_cnt == len) state_nxt = ST_NEXT;
      end
      // Idle cycle lets the final registered oout_valid drain before rewinding.
      ST_NEXT: begin
        if (opass == NPW'(npass - 1'b1)) begin
          state_nxt = ST_DONE;
        end else begin
          pass_inc_c = 1'b1;
          state_nxt  = ST_REWIND;
        end
      end
      ST_DONE: begin
        odone     = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign fifo.ofifo_write = write_c;
  assign fifo.ofifo_read  = read_c;
  assign fifo.ofifo_rrst  = rrst_c;
  assign fifo.ofifo_wrst  = wrst_c;

  // Batch parameters, counters and the registered read-side qualifiers.
  always_ff @(posedge iclk) begin
    if (iresetn) begin
      len        <= '0;
      npass      <= '0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      opass      <= '0;
      oout_valid <= 1'b0;
      oout_last  <= 1'b0;
      oerr       <= 1'b0;
    end else begin
      oout_valid <= read_c;
      oout_last  <= read_c && (rd_cnt == NDEPTH'(len - 1'b1));
      // Fifo reports it has nothing left while we still owe reads.
      if (read_c && fifo.ififo_end) oerr <= 1'b1;
      if (start_c) begin
        len   <= ilen;
        npass <= (inpass == '0) ? NPW'(1) : inpass;
        opass <= '0;
      end
      if (wrst_c)       wr_cnt <= '0;
      else if (write_c) wr_cnt <= wr_cnt + 1'b1;
      if (rrst_c)       rd_cnt <= '0;
      else if (read_c)  rd_cnt <= rd_cnt + 1'b1;
      if (pass_inc_c)   opass  <= opass + 1'b1;
    end
  end

endmodule
